zmc2_dot_gen: RTL and testbench
===============================

Name: zmc2_dot_gen

Overview:
- Parametrised successor to the ZMC2 dot serialiser.
- Captures a planar sprite graphics word from CR and emits two pixels per advance step to the A/B line-buffer pixel buses.
- Generalised in bits-per-pixel and pixels-per-word. Adds a two-entry load buffer (active + staged) for seamless back-to-back tiles, advance gating, and status/overflow flags.
- Sits between the sprite ROM data bus and the line-buffer write logic, in the CLK_12M domain.

Parameters:
- BPP, 4, bits per pixel (number of bitplanes); legal 1..8.
- PIX, 8, pixels per loaded word; must be even, 2..32.

Ports:
- CLK_12M  in  1  sole clock; all state changes on its rising edge.
- nRESET  in  1  asynchronous active-low reset.
- LOAD  in  1  capture-strobe qualifier; CR, H sampled when 1.
- CR  in  BPP*PIX  planar word; bit b of pixel i = CR[b*PIX+i].
- H  in  1  horizontal flip for the word being loaded.
- EVEN  in  1  lane select for the pair being emitted.
- ADV  in  1  advance: emit one pixel pair this cycle.
- GAD  out  BPP  lane A pixel.
- GBD  out  BPP  lane B pixel.
- DOTA  out  1  GAD non-zero (opaque).
- DOTB  out  1  GBD non-zero.
- EMPTY  out  1  no active word.
- FULL  out  1  staged entry occupied.
- OVF  out  1  sticky: a LOAD was dropped.

Behaviour:
- Reset (async, nRESET=0):
  - GAD=GBD=0; DOTA=DOTB=0; EMPTY=1; FULL=0; OVF=0.
  - Active and staged entries invalid; step counter=0.
  - Reset mid-word discards both entries immediately.
- Storage: active entry {word, flip, step counter 0..PIX/2-1}; staged entry {word, flip}.
- Pixel order:
  - flip=0: pixel 0,1,...,PIX-1.
  - flip=1: PIX-1,...,0.
  - Step s emits first=order[2s], second=order[2s+1].
- Lane mapping: EVEN sampled in the same cycle as ADV.
  - EVEN=1: GAD=first, GBD=second.
  - EVEN=0: GAD=second, GBD=first.
- Outputs are registered. For ADV=1 with a valid active entry in the cycle ending at edge k:
  - The pair is visible after edge k.
  - The step counter increments.
  - After step PIX/2-1 the active entry retires.
- ADV=1 with no active entry: GAD=GBD=0, DOTA=DOTB=0 (transparent fill).
- ADV=0: outputs hold their values; the counter holds.
- DOTA = (GAD!=0); DOTB = (GBD!=0). Both are registered alongside the data.
- Load latency: LOAD at edge k into an empty block makes the entry active after edge k. With ADV=1 in the next cycle, the first pair appears after edge k+1.
- LOAD rules, evaluated per edge with "retire" = ADV & active valid & last step:
  - Active empty: word goes to active (staged is necessarily empty).
  - Active valid, not retiring, staged empty: word goes to staged; FULL=1.
  - Active retiring, staged empty: word goes directly to active with counter=0, giving seamless continuation.
  - Active retiring, staged full: staged promotes to active; new word goes to staged; FULL stays 1.
  - Active valid, not retiring, staged full: word dropped; OVF set (sticky until reset); state otherwise unchanged.
- Retire without LOAD: staged promotes to active (counter=0, FULL=0) if present; otherwise active becomes invalid (EMPTY=1 after the edge).
- Invariant: staged is never valid while active is invalid.
- EMPTY and FULL are registered and reflect state after each edge.

Test Plan:
- BPP=4, PIX=8. LOAD CR=0x80786655, H=0, then ADV=1, EVEN=1 for 5 cycles -> GAD/GBD = 1/2, 3/4, 5/6, 7/8, then 0/0 with DOTA=DOTB=0. EMPTY=0 after the LOAD edge; EMPTY=1 after the 4th step.
- Same word, H=1, EVEN=1 -> 8/7, 6/5, 4/3, 2/1. Repeat with EVEN=0 -> 7/8, 5/6, 3/4, 1/2.
- LOAD CR=0x00000000 then advance -> GAD=GBD=0, DOTA=DOTB=0 for 4 steps while EMPTY=0. Then LOAD CR=0x0000000F -> pixels 0..3 =1, so the first two steps give DOTA=DOTB=1 and the last two give DOT=0.
- Back-to-back: LOAD 0x80786655 (H=0), LOAD same word with H=1 on the next cycle (FULL=1), ADV continuous -> 8 consecutive pairs 1/2..7/8, 8/7..2/1 with no gap; FULL=0 after the 4th step. A third LOAD on a retire edge is accepted into staged with no OVF.
- Overflow: active and staged both valid, ADV=0, LOAD a third word -> OVF=1 and stays 1. The subsequent drain emits only the first two words.
- Assert nRESET mid-word (after 2 steps) -> immediately GAD=GBD=0, EMPTY=1, FULL=0, OVF=0. After release, ADV produces 0/0 until a new LOAD.
- ADV=0 for 3 cycles mid-word -> outputs hold the last pair; resumes at the next step without skipping.

Source files
------------

// File: rtl/zmc2_dot_gen.sv
// Planar sprite dot serialiser: captures a BPP x PIX planar word and emits two
// pixels per advance step onto the A/B line-buffer lanes, with a staged load slot.
module zmc2_dot_gen #(
    parameter int BPP = 4,
    parameter int PIX = 8
) (
    input  logic               CLK_12M,
    input  logic               nRESET,
    input  logic               LOAD,
    input  logic [BPP*PIX-1:0] CR,
    input  logic               H,
    input  logic               EVEN,
    input  logic               ADV,
    output logic [BPP-1:0]     GAD,
    output logic [BPP-1:0]     GBD,
    output logic               DOTA,
    output logic               DOTB,
    output logic               EMPTY,
    output logic               FULL,
    output logic               OVF
);

    localparam int WW    = BPP * PIX;
    localparam int STEPS = PIX / 2;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    logic          act_vld;
    logic          act_flip;
    logic [WW-1:0] act_word;
    logic [SW-1:0] step;
    logic          stg_vld;
    logic          stg_flip;
    logic [WW-1:0] stg_word;
    logic          ovf;

    logic          retire;
    logic          promote;
    logic          take_act;
    logic          take_stg;
    logic          drop;
    logic [BPP-1:0] first_p0;
    logic [BPP-1:0] second_p0;

    logic [BPP-1:0] pix_a_p1;
    logic [BPP-1:0] pix_b_p1;
    logic           dot_a_p1;
    logic           dot_b_p1;

    // Gathers one pixel from the planar word; n counts along the display order.
    function automatic logic [BPP-1:0] pix_at(input logic [WW-1:0] w, input logic f,
                                              input int n);
        logic [BPP-1:0] p;
        logic [WW-1:0]  sh;
        int             i;
        i = f ? (PIX - 1 - n) : n;
        p = '0;
        for (int b = 0; b < BPP; b++) begin
            sh   = w >> (b * PIX + i);
            p[b] = sh[0];
        end
        return p;
    endfunction

    // Stage p0: load arbitration and pixel pair selection
    always_comb begin
        retire    = ADV & act_vld & (step == LAST_STEP);
        promote   = retire & stg_vld;
        take_act  = LOAD & (~act_vld | (retire & ~stg_vld));
        take_stg  = LOAD & act_vld & (retire ? stg_vld : ~stg_vld);
        drop      = LOAD & act_vld & ~retire & stg_vld;
        first_p0  = pix_at(act_word, act_flip, 2 * int'(step));
        second_p0 = pix_at(act_word, act_flip, 2 * int'(step) + 1);
    end

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            act_vld <= 1'b0;
            stg_vld <= 1'b0;
            step    <= '0;
            ovf     <= 1'b0;
        end else begin
            if (retire) begin
                act_vld <= stg_vld | LOAD;
                step    <= '0;
            end else if (!act_vld) begin
                act_vld <= LOAD;
                step    <= '0;
            end else if (ADV) begin
                step <= step + SW'(1);
            end

            if (take_stg) begin
                stg_vld <= 1'b1;
            end else if (promote) begin
                stg_vld <= 1'b0;
            end

            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Word storage carries no reset; validity flags alone qualify it.
    always_ff @(posedge CLK_12M) begin
        if (promote) begin
            act_word <= stg_word;
            act_flip <= stg_flip;
        end else if (take_act) begin
            act_word <= CR;
            act_flip <= H;
        end
        if (take_stg) begin
            stg_word <= CR;
            stg_flip <= H;
        end
    end

    // Stage p1: registered lane outputs
    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            pix_a_p1 <= '0;
            pix_b_p1 <= '0;
            dot_a_p1 <= 1'b0;
            dot_b_p1 <= 1'b0;
        end else if (ADV) begin
            if (act_vld) begin
                pix_a_p1 <= EVEN ? first_p0 : second_p0;
                pix_b_p1 <= EVEN ? second_p0 : first_p0;
                dot_a_p1 <= (EVEN ? first_p0 : second_p0) != '0;
                dot_b_p1 <= (EVEN ? second_p0 : first_p0) != '0;
            end else begin
                pix_a_p1 <= '0;
                pix_b_p1 <= '0;
                dot_a_p1 <= 1'b0;
                dot_b_p1 <= 1'b0;
            end
        end
    end

    assign GAD   = pix_a_p1;
    assign GBD   = pix_b_p1;
    assign DOTA  = dot_a_p1;
    assign DOTB  = dot_b_p1;
    assign EMPTY = ~act_vld;
    assign FULL  = stg_vld;
    assign OVF   = ovf;

endmodule

// File: tb/tb_zmc2_dot_gen.sv
// Bench for zmc2_dot_gen: queue-based reference model checked every cycle,
// plus hand-computed pixel pairs and flags from directed vectors.
module tb_zmc2_dot_gen;

    localparam int BPP = 4;
    localparam int PIX = 8;
    localparam int WW  = BPP * PIX;
    localparam logic [WW-1:0] WORD_A = 32'h8078_6655;
    localparam logic [WW-1:0] WORD_F = 32'h0000_000F;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           load;
    logic [WW-1:0]  cr;
    logic           h;
    logic           even;
    logic           adv;
    logic [BPP-1:0] gad;
    logic [BPP-1:0] gbd;
    logic           dota;
    logic           dotb;
    logic           empty;
    logic           full;
    logic           ovf;

    always #5 clk = ~clk;

    zmc2_dot_gen #(.BPP(BPP), .PIX(PIX)) dut (
        .CLK_12M(clk),
        .nRESET (rst_n),
        .LOAD   (load),
        .CR     (cr),
        .H      (h),
        .EVEN   (even),
        .ADV    (adv),
        .GAD    (gad),
        .GBD    (gbd),
        .DOTA   (dota),
        .DOTB   (dotb),
        .EMPTY  (empty),
        .FULL   (full),
        .OVF    (ovf)
    );

    typedef struct packed {
        logic [WW-1:0] w;
        logic          f;
    } ent_t;

    ent_t           mq[$];
    int             mpos;
    logic           m_ovf;
    logic [BPP-1:0] e_a;
    logic [BPP-1:0] e_b;
    int             n_chk = 0;
    int             n_fail = 0;

    function automatic logic [BPP-1:0] ref_pix(logic [WW-1:0] w, logic f, int k);
        logic [WW-1:0] sh;
        int i;
        int v;
        i = f ? (PIX - 1 - k) : k;
        v = 0;
        for (int b = 0; b < BPP; b++) begin
            sh = w >> (b * PIX + i);
            if (sh[0]) v += (1 << b);
        end
        return BPP'(v);
    endfunction

    task automatic model_reset();
        mq.delete();
        mpos  = 0;
        m_ovf = 1'b0;
        e_a   = '0;
        e_b   = '0;
    endtask

    // The queue front is the active word; a second element is the staged one.
    task automatic model_step(logic ld, logic [WW-1:0] w, logic f, logic a, logic ev);
        logic [BPP-1:0] fst;
        logic [BPP-1:0] snd;
        ent_t e;
        if (a) begin
            if (mq.size() > 0) begin
                fst = ref_pix(mq[0].w, mq[0].f, 2 * mpos);
                snd = ref_pix(mq[0].w, mq[0].f, 2 * mpos + 1);
                e_a = ev ? fst : snd;
                e_b = ev ? snd : fst;
                mpos++;
                if (mpos == PIX / 2) begin
                    void'(mq.pop_front());
                    mpos = 0;
                end
            end else begin
                e_a = '0;
                e_b = '0;
            end
        end
        if (ld) begin
            if (mq.size() < 2) begin
                e.w = w;
                e.f = f;
                mq.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("model_gad",   int'(gad),   int'(e_a));
        chk("model_gbd",   int'(gbd),   int'(e_b));
        chk("model_dota",  int'(dota),  int'(e_a != '0));
        chk("model_dotb",  int'(dotb),  int'(e_b != '0));
        chk("model_empty", int'(empty), int'(mq.size() == 0));
        chk("model_full",  int'(full),  int'(mq.size() == 2));
        chk("model_ovf",   int'(ovf),   int'(m_ovf));
    endtask

    task automatic tick(logic ld, logic [WW-1:0] w, logic f, logic a, logic ev);
        @(negedge clk);
        compare_all();
        load = ld;
        cr   = w;
        h    = f;
        adv  = a;
        even = ev;
        model_step(ld, w, f, a, ev);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_pair(string nm, int ga, int gb, int da, int db);
        chk({nm, "_gad"},  int'(gad),  ga);
        chk({nm, "_gbd"},  int'(gbd),  gb);
        chk({nm, "_dota"}, int'(dota), da);
        chk({nm, "_dotb"}, int'(dotb), db);
    endtask

    task automatic lit_flags(string nm, int e, int f, int o);
        chk({nm, "_empty"}, int'(empty), e);
        chk({nm, "_full"},  int'(full),  f);
        chk({nm, "_ovf"},   int'(ovf),   o);
    endtask

    task automatic adv_expect(string nm, logic ev, int ga, int gb);
        tick(1'b0, '0, 1'b0, 1'b1, ev);
        settle();
        lit_pair(nm, ga, gb, int'(ga != 0), int'(gb != 0));
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        cr    = '0;
        h     = 1'b0;
        even  = 1'b0;
        adv   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        lit_pair("rst", 0, 0, 0, 0);
        lit_flags("rst", 1, 0, 0);
        rst_n = 1'b1;

        // Single word, no flip, EVEN=1
        tick(1'b1, WORD_A, 1'b0, 1'b0, 1'b1);
        settle();
        lit_flags("t1_load", 0, 0, 0);
        adv_expect("t1_s0", 1'b1, 1, 2);
        adv_expect("t1_s1", 1'b1, 3, 4);
        adv_expect("t1_s2", 1'b1, 5, 6);
        adv_expect("t1_s3", 1'b1, 7, 8);
        lit_flags("t1_done", 1, 0, 0);
        adv_expect("t1_fill", 1'b1, 0, 0);

        // Flipped word on both lane assignments
        tick(1'b1, WORD_A, 1'b1, 1'b0, 1'b1);
        adv_expect("t2_s0", 1'b1, 8, 7);
        adv_expect("t2_s1", 1'b1, 6, 5);
        adv_expect("t2_s2", 1'b1, 4, 3);
        adv_expect("t2_s3", 1'b1, 2, 1);
        tick(1'b1, WORD_A, 1'b1, 1'b0, 1'b0);
        adv_expect("t2e_s0", 1'b0, 7, 8);
        adv_expect("t2e_s1", 1'b0, 5, 6);
        adv_expect("t2e_s2", 1'b0, 3, 4);
        adv_expect("t2e_s3", 1'b0, 1, 2);

        // Transparent word keeps the block busy; then partially opaque word
        tick(1'b1, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            adv_expect("t3_zero", 1'b1, 0, 0);
            lit_flags("t3_busy", 0, 0, 0);
        end
        adv_expect("t3_zero_last", 1'b1, 0, 0);
        lit_flags("t3_done", 1, 0, 0);
        tick(1'b1, WORD_F, 1'b0, 1'b0, 1'b1);
        adv_expect("t3f_s0", 1'b1, 1, 1);
        adv_expect("t3f_s1", 1'b1, 1, 1);
        adv_expect("t3f_s2", 1'b1, 0, 0);
        adv_expect("t3f_s3", 1'b1, 0, 0);

        // Back-to-back tiles, third load on the first word's retire edge
        tick(1'b1, WORD_A, 1'b0, 1'b0, 1'b1);
        tick(1'b1, WORD_A, 1'b1, 1'b1, 1'b1);
        settle();
        lit_pair("t4_s0", 1, 2, 1, 1);
        lit_flags("t4_staged", 0, 1, 0);
        adv_expect("t4_s1", 1'b1, 3, 4);
        adv_expect("t4_s2", 1'b1, 5, 6);
        tick(1'b1, WORD_F, 1'b0, 1'b1, 1'b1);
        settle();
        lit_pair("t4_s3", 7, 8, 1, 1);
        lit_flags("t4_retire_load", 0, 1, 0);
        adv_expect("t4_s4", 1'b1, 8, 7);
        adv_expect("t4_s5", 1'b1, 6, 5);
        adv_expect("t4_s6", 1'b1, 4, 3);
        adv_expect("t4_s7", 1'b1, 2, 1);
        lit_flags("t4_promote", 0, 0, 0);
        adv_expect("t4_s8", 1'b1, 1, 1);
        adv_expect("t4_s9", 1'b1, 1, 1);
        adv_expect("t4_s10", 1'b1, 0, 0);
        adv_expect("t4_s11", 1'b1, 0, 0);
        lit_flags("t4_done", 1, 0, 0);

        // Overflow: third load while both slots hold and nothing advances
        tick(1'b1, WORD_A, 1'b0, 1'b0, 1'b1);
        tick(1'b1, WORD_A, 1'b1, 1'b0, 1'b1);
        tick(1'b1, WORD_F, 1'b0, 1'b0, 1'b1);
        settle();
        lit_flags("t5_ovf", 0, 1, 1);
        adv_expect("t5_s0", 1'b1, 1, 2);
        adv_expect("t5_s1", 1'b1, 3, 4);
        adv_expect("t5_s2", 1'b1, 5, 6);
        adv_expect("t5_s3", 1'b1, 7, 8);
        adv_expect("t5_s4", 1'b1, 8, 7);
        adv_expect("t5_s5", 1'b1, 6, 5);
        adv_expect("t5_s6", 1'b1, 4, 3);
        adv_expect("t5_s7", 1'b1, 2, 1);
        adv_expect("t5_fill", 1'b1, 0, 0);
        lit_flags("t5_sticky", 1, 0, 1);

        // Asynchronous reset mid-word
        tick(1'b1, WORD_A, 1'b0, 1'b0, 1'b1);
        tick(1'b1, WORD_A, 1'b1, 1'b0, 1'b1);
        adv_expect("t6_s0", 1'b1, 1, 2);
        adv_expect("t6_s1", 1'b1, 3, 4);
        @(negedge clk);
        compare_all();
        load  = 1'b0;
        adv   = 1'b0;
        rst_n = 1'b0;
        #1;
        lit_pair("t6_rst", 0, 0, 0, 0);
        lit_flags("t6_rst", 1, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        adv_expect("t6_after0", 1'b1, 0, 0);
        adv_expect("t6_after1", 1'b1, 0, 0);
        lit_flags("t6_after", 1, 0, 0);

        // Advance stall mid-word
        tick(1'b1, WORD_A, 1'b0, 1'b0, 1'b1);
        adv_expect("t7_s0", 1'b1, 1, 2);
        adv_expect("t7_s1", 1'b1, 3, 4);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, 1'b0, 1'b0, logic'(i[0]));
            settle();
            lit_pair("t7_hold", 3, 4, 1, 1);
        end
        adv_expect("t7_s2", 1'b1, 5, 6);
        adv_expect("t7_s3", 1'b1, 7, 8);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
